microcode_sequencer: RTL and testbench

Parametrised, writable-microcode successor to the CPU control unit. It steps each instruction through a hardwired two-step fetch followed by programmable execute microwords. The execute microwords support variable-length instructions, conditional steps and a halt/resume state machine. It sits between the instruction register, the ALU flags and every datapath control input, and drives one control vector.

---
 rtl/microcode_sequencer.sv | 152 +++++++++++++++
 tb/tb_microcode_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: writable-microcode control unit.
// Every instruction runs two hardwired fetch steps and then execute microwords
// read from [instruction][step]. An execute microword can be conditional on the
// ALU flags, can end the instruction early, and can halt the machine. While the
// machine is halted, the microcode can be rewritten. All state moves on the
// falling clock edge, so ctrl has settled by the datapath's rising edge.
//
// Ports
//   clk, rst_n    falling-edge clock; asynchronous active-low reset
//   instruction   opcode from the instruction register
//   alu_carry     latched ALU carry flag
//   alu_zero      latched ALU zero flag
//   resume        leave HALTED
//   ucode_we      microcode write strobe
//   ucode_opcode  write address: opcode
//   ucode_step    write address: step
//   ucode_wdata   microword {cond[1:0], end, ctrl}
//   ctrl          control vector (combinational)
//   step          current step counter (registered)
//   halted        high while HALTED (registered)
//   ucode_err     one-cycle pulse after a rejected write
module microcode_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int N_STEPS  = 8,
    parameter int CTRL_W   = 17,
    parameter int STEP_W   = $clog2(N_STEPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] instruction,
    input  logic                alu_carry,
    input  logic                alu_zero,
    input  logic                resume,
    input  logic                ucode_we,
    input  logic [OPCODE_W-1:0] ucode_opcode,
    input  logic [STEP_W-1:0]   ucode_step,
    input  logic [CTRL_W+2:0]   ucode_wdata,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [STEP_W-1:0]   step,
    output logic                halted,
    output logic                ucode_err
);
    localparam int N_OPS  = 1 << OPCODE_W;
    localparam int WORD_W = CTRL_W + 3;

    localparam logic [CTRL_W-1:0] FETCH0    = CTRL_W'(32'h00402);  // PC_OUT|MAR_READ
    localparam logic [CTRL_W-1:0] FETCH1    = CTRL_W'(32'h01104);  // RAM_WRITE|I_READ|PC_INC
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_TWO  = STEP_W'(2);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);
    localparam logic [STEP_W:0]   STEP_LIM  = (STEP_W + 1)'(N_STEPS);

    // Reset microwords. Every step 2 ends the instruction. The all-ones opcode also halts.
    localparam logic [WORD_W-1:0] END_WORD  = {2'b00, 1'b1, {CTRL_W{1'b0}}};
    localparam logic [WORD_W-1:0] HALT_WORD = END_WORD | WORD_W'(1);

    typedef enum logic {S_RUN, S_HALTED} state_e;

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                err_q, err_d;
    logic [WORD_W-1:0]   ucode_q [N_OPS][N_STEPS];
    logic [WORD_W-1:0]   word;
    logic                cond_ok;
    logic                is_end;
    logic                step_in_range;
    logic                wr_ok;

    // A step counter that spans exactly N_STEPS cannot address an out-of-range step.
    if (N_STEPS == (1 << STEP_W)) begin : g_full_range
        assign step_in_range = 1'b1;
    end else begin : g_part_range
        assign step_in_range = ({1'b0, ucode_step} < STEP_LIM);
    end

    assign wr_ok = ucode_we && (state_q == S_HALTED) && (ucode_step >= STEP_TWO) && step_in_range;

    // Each microcode entry has its own register, so reset can restore the boot contents.
    for (genvar o = 0; o < N_OPS; o++) begin : g_op
        for (genvar s = 0; s < N_STEPS; s++) begin : g_st
            localparam logic [WORD_W-1:0] RST_WORD =
                (s == 2) ? ((o == N_OPS - 1) ? HALT_WORD : END_WORD) : {WORD_W{1'b0}};
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n)
                    ucode_q[o][s] <= RST_WORD;
                else if (wr_ok && ucode_opcode == OPCODE_W'(o) && ucode_step == STEP_W'(s))
                    ucode_q[o][s] <= ucode_wdata;
            end
        end
    end

    // Effective control word. A failed condition blanks ctrl and also ends the instruction.
    always_comb begin
        word    = ucode_q[instruction][step_q];
        cond_ok = 1'b1;
        ctrl    = '0;
        is_end  = 1'b0;
        case (word[WORD_W-1 -: 2])
            2'd0:    cond_ok = 1'b1;
            2'd1:    cond_ok = alu_carry;
            2'd2:    cond_ok = alu_zero;
            default: cond_ok = !alu_zero;
        endcase
        if (state_q == S_RUN) begin
            if (step_q == '0)
                ctrl = FETCH0;
            else if (step_q == STEP_ONE)
                ctrl = FETCH1;
            else begin
                ctrl   = cond_ok ? word[CTRL_W-1:0] : '0;
                is_end = !cond_ok || word[CTRL_W] || (step_q == LAST_STEP);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        err_d   = ucode_we && !wr_ok;
        case (state_q)
            S_RUN: begin
                if (ctrl[0]) begin
                    state_d = S_HALTED;
                    step_d  = '0;
                end else if (is_end)
                    step_d = '0;
                else
                    step_d = step_q + STEP_ONE;
            end
            default: begin
                step_d = '0;
                if (resume) state_d = S_RUN;
            end
        endcase
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            step_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign step      = step_q;
    assign halted    = (state_q == S_HALTED);
    assign ucode_err = err_q;
endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;
    localparam int NS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  instruction = '0;
    logic        alu_carry = 1'b0, alu_zero = 1'b0, resume = 1'b0, ucode_we = 1'b0;
    logic [3:0]  ucode_opcode = '0;
    logic [2:0]  ucode_step = '0;
    logic [19:0] ucode_wdata = '0;
    logic [16:0] ctrl;
    logic [2:0]  step;
    logic        halted, ucode_err;

    microcode_sequencer dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .resume(resume),
        .ucode_we(ucode_we), .ucode_opcode(ucode_opcode), .ucode_step(ucode_step),
        .ucode_wdata(ucode_wdata), .ctrl(ctrl), .step(step), .halted(halted),
        .ucode_err(ucode_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Reference model: a table of microwords, a step counter and a halted flag.
    logic [19:0] m_mem [16][8];
    bit          m_halt, m_err;
    int          m_step;

    logic [16:0] o_ctrl;
    int          o_step;
    bit          o_halt, o_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int o = 0; o < 16; o++)
            for (int s = 0; s < NS; s++)
                m_mem[o][s] = (s == 2) ? ((o == 15) ? 20'h20001 : 20'h20000) : 20'h0;
        m_halt = 0; m_err = 0; m_step = 0;
    endfunction

    // Expected ctrl and end-of-instruction for the current model state and inputs.
    function automatic void meval(output logic [16:0] c, output bit e);
        logic [19:0] w;
        bit ok;
        c = '0; e = 0;
        if (m_halt) begin
            c = '0;
        end else if (m_step == 0) begin
            c = 17'h00402;
        end else if (m_step == 1) begin
            c = 17'h01104;
        end else begin
            w = m_mem[instruction][m_step];
            case (w[19:18])
                2'd0: ok = 1;
                2'd1: ok = alu_carry;
                2'd2: ok = alu_zero;
                default: ok = !alu_zero;
            endcase
            c = ok ? w[16:0] : 17'h0;
            e = !ok || w[17] || (m_step == NS - 1);
        end
    endfunction

    // Each cycle: compare the outputs at the rising edge, then advance the model at the falling edge.
    task automatic cyc();
        logic [16:0] c;
        bit e, acc;
        @(posedge clk); #1;
        meval(c, e);
        o_ctrl = ctrl; o_step = int'(step); o_halt = halted; o_err = ucode_err;
        chk("ctrl", 32'(o_ctrl), 32'(c));
        chk("step", o_step, m_step);
        chk("halted", 32'(o_halt), 32'(m_halt));
        chk("ucode_err", 32'(o_err), 32'(m_err));
        @(negedge clk);
        meval(c, e);
        acc   = ucode_we && m_halt && (ucode_step >= 3'd2);
        m_err = ucode_we && !acc;
        if (m_halt) begin
            if (resume) m_halt = 0;
            m_step = 0;
        end else if (c[0]) begin
            m_halt = 1; m_step = 0;
        end else if (e) m_step = 0;
        else m_step++;
        if (acc) m_mem[ucode_opcode][ucode_step] = ucode_wdata;
        #1;
    endtask

    task automatic wr(input logic [3:0] op, input logic [2:0] st, input logic [19:0] d, input bit res);
        ucode_we = 1; ucode_opcode = op; ucode_step = st; ucode_wdata = d; resume = res;
        cyc();
        ucode_we = 0; resume = 0;
    endtask

    initial begin
        // Reset state
        model_reset();
        #3;
        chk("rst_ctrl", 32'(ctrl), 32'h00402);
        chk("rst_step", 32'(step), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_err", 32'(ucode_err), 0);
        #9 rst_n = 1;

        // Default sequence with opcode 0
        cyc(); chk("def_c0", 32'(o_ctrl), 32'h00402); chk("def_s0", o_step, 0);
        cyc(); chk("def_c1", 32'(o_ctrl), 32'h01104); chk("def_s1", o_step, 1);
        cyc(); chk("def_c2", 32'(o_ctrl), 32'h00000); chk("def_s2", o_step, 2);
        cyc(); chk("def_c3", 32'(o_ctrl), 32'h00402); chk("def_s3", o_step, 0);

        // Halt with opcode F
        instruction = 4'hF;
        cyc();
        cyc(); chk("halt_ctrl", 32'(o_ctrl), 32'h00001); chk("halt_step", o_step, 2);
        cyc(); chk("halted_hi", 32'(o_halt), 1); chk("halted_ctrl", 32'(o_ctrl), 0);

        // Program opcode 1 and resume
        wr(4'd1, 3'd2, 20'h00600, 0);
        wr(4'd1, 3'd3, 20'h21010, 0);
        cyc(); chk("wr_ok_err", 32'(o_err), 0);
        resume = 1; instruction = 4'd1;
        cyc(); resume = 0;
        cyc(); chk("op1_c0", 32'(o_ctrl), 32'h00402);
        cyc(); chk("op1_c1", 32'(o_ctrl), 32'h01104);
        cyc(); chk("op1_c2", 32'(o_ctrl), 32'h00600);
        cyc(); chk("op1_c3", 32'(o_ctrl), 32'h01010);
        cyc(); chk("op1_c4", 32'(o_ctrl), 32'h00402);

        // Write in RUN is rejected
        ucode_we = 1; ucode_opcode = 4'd1; ucode_step = 3'd2; ucode_wdata = 20'h0FFFF;
        cyc(); ucode_we = 0;
        cyc(); chk("run_wr_err", 32'(o_err), 1); chk("run_wr_keep", 32'(o_ctrl), 32'h00600);
        cyc(); chk("run_wr_err_clr", 32'(o_err), 0); chk("run_wr_c3", 32'(o_ctrl), 32'h01010);

        // Halt again, then a write to step 1 is rejected and a write to step 2 is accepted
        instruction = 4'hF;
        cyc(); cyc(); cyc();
        cyc(); chk("halted2", 32'(o_halt), 1);
        wr(4'd1, 3'd1, 20'h0ABCD, 0);
        cyc(); chk("st1_err", 32'(o_err), 1);
        wr(4'd7, 3'd2, 20'h60208, 0);
        cyc(); chk("st2_no_err", 32'(o_err), 0);

        // Wrap without end; the last write coincides with resume
        instruction = 4'd2;
        for (int s = 2; s < 7; s++) wr(4'd2, 3'(s), 20'h00010, 0);
        wr(4'd2, 3'd7, 20'h00010, 1);
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("wrap_step", o_step, i % 8);
            if (i >= 2 && i < 8) chk("wrap_ctrl", 32'(o_ctrl), 32'h00010);
        end

        // Conditional on carry
        instruction = 4'd7; alu_carry = 0;
        cyc();
        cyc(); chk("c0_ctrl", 32'(o_ctrl), 0);
        cyc(); chk("c0_next", o_step, 0);
        alu_carry = 1;
        cyc();
        cyc(); chk("c1_ctrl", 32'(o_ctrl), 32'h00208);
        cyc(); chk("c1_next", o_step, 0);

        // Conditional on !zero with zero=1
        instruction = 4'hF;
        cyc(); cyc(); cyc();
        wr(4'd7, 3'd2, 20'hE0208, 1);
        instruction = 4'd7; alu_zero = 1;
        cyc(); cyc();
        cyc(); chk("nz_ctrl", 32'(o_ctrl), 0);
        cyc(); chk("nz_next", o_step, 0);

        // Reset in the middle of opcode 1
        instruction = 4'd1; alu_zero = 0;
        cyc();
        cyc(); chk("pre_rst_c2", 32'(o_ctrl), 32'h00600);
        #2 chk("pre_rst_step", 32'(step), 3);
        rst_n = 0;
        #1 chk("mid_rst_step", 32'(step), 0);
        chk("mid_rst_ctrl", 32'(ctrl), 32'h00402);
        model_reset();
        @(negedge clk); #1 rst_n = 1;
        cyc(); cyc();
        cyc(); chk("revert_ctrl", 32'(o_ctrl), 0);
        cyc(); chk("revert_end", o_step, 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            instruction  = 4'($urandom_range(0, 15));
            alu_carry    = 1'($urandom);
            alu_zero     = 1'($urandom);
            resume       = ($urandom_range(0, 3) == 0);
            ucode_we     = ($urandom_range(0, 2) == 0);
            ucode_opcode = 4'($urandom_range(0, 15));
            ucode_step   = 3'($urandom_range(0, 7));
            ucode_wdata  = 20'($urandom);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
